edge_event_bank: RTL and testbench
==================================

Name: edge_event_bank

Overview:
- Parametrised multi-channel successor to the single-bit edge detector.
- Per channel it performs:
  - synchronisation of an asynchronous level input;
  - optional debounce by a programmable stable-count;
  - registered rising/falling edge pulses;
  - sticky, individually clearable event flags.
- Sits between raw board inputs (buttons, switches, external strobes) and control logic, and provides a single OR-reduced interrupt line.

Parameters:
- CHANNELS, 8: number of independent input channels (1..32).
- SYNC_STAGES, 2: flip-flop stages in each input synchroniser (2..4).
- DEBOUNCE_CYCLES, 16: consecutive cycles a synchronised value must differ from the stable value before it is accepted. 0 or 1 means no debounce.
- CNT_W, $clog2(DEBOUNCE_CYCLES+1): width of each debounce counter. Derived; not overridden.

Ports:
- clk, input, 1: single clock; all state is on its rising edge.
- reset, input, 1: asynchronous, active-high reset.
- level, input, CHANNELS: raw asynchronous levels, one bit per channel.
- rise_enable, input, CHANNELS: per-channel enable for latching rising edges into event_pending.
- fall_enable, input, CHANNELS: per-channel enable for latching falling edges into event_pending.
- event_clear, input, CHANNELS: one-cycle clear strobe per channel for event_pending.
- stable_level, output, CHANNELS: debounced level, registered.
- pos_edge, output, CHANNELS: one-cycle pulse when stable_level goes 0->1, registered.
- neg_edge, output, CHANNELS: one-cycle pulse when stable_level goes 1->0, registered.
- any_edge, output, CHANNELS: pos_edge | neg_edge, combinational from registers.
- event_pending, output, CHANNELS: sticky flags.
- irq, output, 1: OR of all event_pending bits, registered.

Behaviour:
- Reset (asynchronous, while high) clears to 0:
  - all synchroniser flops;
  - debounce counters;
  - stable_level, pos_edge, neg_edge, event_pending, irq.
  - Outputs are 0 while reset is asserted and in the first cycle after release.
- Synchroniser:
  - sync[i] is level[i] delayed through SYNC_STAGES flops.
  - No logic is placed between stages.
- Debounce, per channel, with DEBOUNCE_CYCLES >= 2:
  - If sync == stable_level: counter <= 0.
  - Else if counter == DEBOUNCE_CYCLES-1: stable_level <= sync and counter <= 0.
  - Else: counter <= counter+1.
  - A single-cycle glitch, or any run shorter than DEBOUNCE_CYCLES cycles, never changes stable_level.
- Bypass (DEBOUNCE_CYCLES 0 or 1):
  - stable_level <= sync every cycle.
  - The counter logic is omitted.
- Edge pulses:
  - pos_edge/neg_edge are asserted in exactly the cycle in which the new stable_level value is visible.
  - Pulses are always exactly one cycle wide.
  - pos_edge and neg_edge are never both high for the same channel.
- Latency from a clean level step to the pos_edge/neg_edge pulse:
  - With debounce: SYNC_STAGES + DEBOUNCE_CYCLES cycles.
  - In bypass: SYNC_STAGES + 1 cycles.
- Power-up:
  - stable_level resets to 0.
  - An input held high through reset produces one pos_edge after the latency above. This is intended.
- event_pending[i], next-state:
  - Set if (pos_edge[i] & rise_enable[i]) | (neg_edge[i] & fall_enable[i]).
  - Else cleared if event_clear[i].
  - Else hold.
  - Set takes priority over a simultaneous clear, so no event is lost.
  - Enables are sampled in the cycle of the edge pulse. Changing an enable never sets or clears a flag by itself.
- irq:
  - Registered OR of event_pending, so it lags event_pending by one cycle.
  - It falls one cycle after the last pending bit clears.
- Channels are fully independent. There is no cross-channel arbitration.
- Reset mid-debounce: counter and stable value are lost. After release the channel re-qualifies from 0.

Test Plan:
1. Reset/idle: CHANNELS=8, level=0x00, reset pulse mid-run -> all outputs 0 during reset and 1 cycle after; no pulses afterwards.
2. Clean rise/fall: DEBOUNCE_CYCLES=16, SYNC_STAGES=2, level[3] 0->1 held 40 cycles, then ->0 -> pos_edge[3] exactly 18 cycles after the step, width 1, stable_level[3]=1 from the same cycle; neg_edge[3] 18 cycles after the fall; any_edge matches; other channels stay 0.
3. Glitch rejection: level[0] high for 15 cycles then low, repeated 5 times -> stable_level[0] stays 0, no pulses. One run of 16 cycles -> a single pos_edge[0].
4. Bypass: DEBOUNCE_CYCLES=0, level[1] toggles every 4 cycles -> stable_level[1] follows the input with 3-cycle latency; pos_edge and neg_edge alternate, each 1 cycle wide.
5. Sticky events: rise_enable=0x01, fall_enable=0x02; rise on ch0, fall on ch1, rise on ch1 -> event_pending=0x03 and irq=1 one cycle later. event_clear=0x01 -> pending=0x02. event_clear=0x02 asserted in the same cycle as a new enabled neg_edge[1] -> pending[1] stays 1.
6. All-channel simultaneous: level 0x00->0xFF with all enables set -> pos_edge=0xFF in one cycle; event_pending=0xFF; event_clear=0xFF -> pending=0x00 next cycle, irq=0 the cycle after.

Source files
------------

// File: rtl/edge_event_bank.sv
// Multi-channel input conditioner: synchroniser, optional debounce, edge pulses,
// sticky per-channel event flags and an OR-reduced interrupt.
module edge_event_bank #(
  parameter int unsigned CHANNELS        = 8,
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [CHANNELS-1:0] level,
  input  logic [CHANNELS-1:0] rise_enable,
  input  logic [CHANNELS-1:0] fall_enable,
  input  logic [CHANNELS-1:0] event_clear,
  output logic [CHANNELS-1:0] stable_level,
  output logic [CHANNELS-1:0] pos_edge,
  output logic [CHANNELS-1:0] neg_edge,
  output logic [CHANNELS-1:0] any_edge,
  output logic [CHANNELS-1:0] event_pending,
  output logic                irq
);

  localparam bit          BYPASS = (DEBOUNCE_CYCLES < 2);
  // Counter is kept at least one bit wide so bypass builds stay legal.
  localparam int unsigned CNT_W  = BYPASS ? 1 : $clog2(DEBOUNCE_CYCLES + 1);

  logic [SYNC_STAGES-1:0][CHANNELS-1:0] sync_q;
  logic [CHANNELS-1:0]                  sync;
  logic [CHANNELS-1:0]                  stable_next;
  logic [CHANNELS-1:0]                  event_set;

  // Plain flop chain per channel, nothing between stages.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
    end else begin
      sync_q[0] <= level;
      for (int s = 1; s < SYNC_STAGES; s++) begin
        sync_q[s] <= sync_q[s-1];
      end
    end
  end

  assign sync = sync_q[SYNC_STAGES-1];

  if (BYPASS) begin : g_bypass
    assign stable_next = sync;
  end else begin : g_debounce
    logic [CHANNELS-1:0][CNT_W-1:0] cnt_q;
    logic [CHANNELS-1:0][CNT_W-1:0] cnt_d;

    // Accept a new value only after it has differed for DEBOUNCE_CYCLES samples.
    always_comb begin
      cnt_d       = cnt_q;
      stable_next = stable_level;
      for (int i = 0; i < CHANNELS; i++) begin
        if (sync[i] == stable_level[i]) begin
          cnt_d[i] = '0;
        end else if (cnt_q[i] == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
          stable_next[i] = sync[i];
          cnt_d[i]       = '0;
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_d;
      end
    end
  end

  // A set in the same cycle as a clear wins so no event is dropped.
  assign event_set = (pos_edge & rise_enable) | (neg_edge & fall_enable);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stable_level  <= '0;
      pos_edge      <= '0;
      neg_edge      <= '0;
      event_pending <= '0;
      irq           <= 1'b0;
    end else begin
      stable_level  <= stable_next;
      pos_edge      <= stable_next & ~stable_level;
      neg_edge      <= ~stable_next & stable_level;
      event_pending <= event_set | (event_pending & ~event_clear);
      irq           <= |event_pending;
    end
  end

  assign any_edge = pos_edge | neg_edge;

endmodule

// File: tb/tb_edge_event_bank.sv
// Directed bench for edge_event_bank: a debounced instance (16 cycles) and a
// bypass instance, both with two synchroniser stages and eight channels.
module tb_edge_event_bank;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] level, rise_enable, fall_enable, event_clear;
  logic [7:0] stable_level, pos_edge, neg_edge, any_edge, event_pending;
  logic       irq;

  logic [7:0] level_b, rise_b, fall_b, clear_b;
  logic [7:0] stable_b, pos_b, neg_b, any_b, pend_b;
  logic       irq_b;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  edge_event_bank #(.CHANNELS(8), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(16)) dut (
    .clk(clk), .reset(reset), .level(level), .rise_enable(rise_enable),
    .fall_enable(fall_enable), .event_clear(event_clear),
    .stable_level(stable_level), .pos_edge(pos_edge), .neg_edge(neg_edge),
    .any_edge(any_edge), .event_pending(event_pending), .irq(irq)
  );

  edge_event_bank #(.CHANNELS(8), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(0)) dut_byp (
    .clk(clk), .reset(reset), .level(level_b), .rise_enable(rise_b),
    .fall_enable(fall_b), .event_clear(clear_b),
    .stable_level(stable_b), .pos_edge(pos_b), .neg_edge(neg_b),
    .any_edge(any_b), .event_pending(pend_b), .irq(irq_b)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [40:0] outs;
    reset = 1'b1;
    tick();
    tick();
    outs = {stable_level, pos_edge, neg_edge, any_edge, event_pending, irq};
    n_cmp++;
    if (outs !== 41'd0) begin
      n_err++;
      $display("FAIL reset_hold: got %h want 0", outs);
    end
    reset = 1'b0;
    tick();
    outs = {stable_level, pos_edge, neg_edge, any_edge, event_pending, irq};
    n_cmp++;
    if (outs !== 41'd0) begin
      n_err++;
      $display("FAIL reset_first_cycle: got %h want 0", outs);
    end
    for (int k = 0; k < 20; k++) begin
      tick();
      n_cmp++;
      if ({any_edge, stable_level, event_pending, irq} !== 25'd0) begin
        n_err++;
        $display("FAIL idle_quiet k=%0d: any=%h stable=%h pend=%h irq=%b want 0",
                 k, any_edge, stable_level, event_pending, irq);
      end
    end
  endtask

  task automatic test_reset_mid_debounce();
    logic [40:0] outs;
    level = 8'h10;
    for (int k = 0; k < 10; k++) tick();
    reset = 1'b1;
    #1;
    outs = {stable_level, pos_edge, neg_edge, any_edge, event_pending, irq};
    n_cmp++;
    if (outs !== 41'd0) begin
      n_err++;
      $display("FAIL reset_async_mid: got %h want 0", outs);
    end
    tick();
    reset = 1'b0;
    tick();
    n_cmp++;
    if ({stable_level, pos_edge} !== 16'd0) begin
      n_err++;
      $display("FAIL reset_release_mid: stable=%h pos=%h want 0", stable_level, pos_edge);
    end
    for (int k = 2; k <= 17; k++) begin
      tick();
      n_cmp++;
      if (pos_edge !== 8'h00) begin
        n_err++;
        $display("FAIL requalify_early k=%0d: pos=%h want 00", k, pos_edge);
      end
    end
    tick();
    n_cmp++;
    if (pos_edge !== 8'h10 || stable_level !== 8'h10) begin
      n_err++;
      $display("FAIL requalify_edge: pos=%h stable=%h want 10/10", pos_edge, stable_level);
    end
    level = 8'h00;
    for (int k = 0; k < 22; k++) tick();
  endtask

  task automatic test_clean_rise_fall();
    level = 8'h08;
    for (int k = 1; k <= 17; k++) begin
      tick();
      n_cmp++;
      if (any_edge !== 8'h00 || stable_level !== 8'h00) begin
        n_err++;
        $display("FAIL rise_early k=%0d: any=%h stable=%h want 00/00", k, any_edge, stable_level);
      end
    end
    tick();
    n_cmp++;
    if ({pos_edge, neg_edge, any_edge, stable_level} !== {8'h08, 8'h00, 8'h08, 8'h08}) begin
      n_err++;
      $display("FAIL rise_pulse: pos=%h neg=%h any=%h stable=%h want 08/00/08/08",
               pos_edge, neg_edge, any_edge, stable_level);
    end
    tick();
    n_cmp++;
    if (any_edge !== 8'h00 || stable_level !== 8'h08) begin
      n_err++;
      $display("FAIL rise_width: any=%h stable=%h want 00/08", any_edge, stable_level);
    end
    for (int k = 0; k < 21; k++) tick();
    level = 8'h00;
    for (int k = 1; k <= 17; k++) begin
      tick();
      n_cmp++;
      if (any_edge !== 8'h00 || stable_level !== 8'h08) begin
        n_err++;
        $display("FAIL fall_early k=%0d: any=%h stable=%h want 00/08", k, any_edge, stable_level);
      end
    end
    tick();
    n_cmp++;
    if ({pos_edge, neg_edge, any_edge, stable_level} !== {8'h00, 8'h08, 8'h08, 8'h00}) begin
      n_err++;
      $display("FAIL fall_pulse: pos=%h neg=%h any=%h stable=%h want 00/08/08/00",
               pos_edge, neg_edge, any_edge, stable_level);
    end
    tick();
    n_cmp++;
    if (any_edge !== 8'h00) begin
      n_err++;
      $display("FAIL fall_width: any=%h want 00", any_edge);
    end
  endtask

  task automatic test_glitch();
    int pulses;
    for (int r = 0; r < 5; r++) begin
      level = 8'h01;
      for (int k = 0; k < 15; k++) tick();
      level = 8'h00;
      for (int k = 0; k < 15; k++) begin
        tick();
        n_cmp++;
        if (any_edge !== 8'h00 || stable_level !== 8'h00) begin
          n_err++;
          $display("FAIL glitch_reject r=%0d k=%0d: any=%h stable=%h want 00/00",
                   r, k, any_edge, stable_level);
        end
      end
    end
    level = 8'h01;
    pulses = 0;
    for (int k = 1; k <= 17; k++) begin
      if (k == 17) level = 8'h00;
      tick();
      if (pos_edge[0]) pulses++;
    end
    level = 8'h00;
    tick();
    n_cmp++;
    if (pos_edge !== 8'h01 || stable_level !== 8'h01 || pulses != 0) begin
      n_err++;
      $display("FAIL glitch_accept16: pos=%h stable=%h early=%0d want 01/01/0",
               pos_edge, stable_level, pulses);
    end
    for (int k = 0; k < 20; k++) begin
      tick();
      if (pos_edge[0]) pulses++;
    end
    n_cmp++;
    if (pulses != 0 || stable_level !== 8'h00) begin
      n_err++;
      $display("FAIL glitch_single: extra_pos=%0d stable=%h want 0/00", pulses, stable_level);
    end
  endtask

  task automatic test_bypass();
    logic v [0:39];
    for (int j = 0; j < 40; j++) v[j] = ((j / 4) % 2) == 0;
    for (int j = 0; j < 40; j++) begin
      level_b = {6'd0, v[j], 1'b0};
      tick();
      if (j >= 3) begin
        n_cmp++;
        if (stable_b[1] !== v[j-2] || pos_b[1] !== (v[j-2] & ~v[j-3]) ||
            neg_b[1] !== (~v[j-2] & v[j-3]) || (pos_b[1] & neg_b[1])) begin
          n_err++;
          $display("FAIL bypass j=%0d: stable=%b pos=%b neg=%b want %b/%b/%b",
                   j, stable_b[1], pos_b[1], neg_b[1],
                   v[j-2], v[j-2] & ~v[j-3], ~v[j-2] & v[j-3]);
        end
      end
    end
    level_b = 8'h00;
  endtask

  task automatic test_sticky();
    rise_enable = 8'h01;
    fall_enable = 8'h02;
    level = 8'h03;
    for (int k = 0; k < 18; k++) tick();
    n_cmp++;
    if (pos_edge !== 8'h03) begin
      n_err++;
      $display("FAIL sticky_rise_pulse: pos=%h want 03", pos_edge);
    end
    tick();
    n_cmp++;
    if (event_pending !== 8'h01 || irq !== 1'b0) begin
      n_err++;
      $display("FAIL sticky_rise_ch0: pend=%h irq=%b want 01/0", event_pending, irq);
    end
    tick();
    n_cmp++;
    if (irq !== 1'b1) begin
      n_err++;
      $display("FAIL sticky_irq_rise: irq=%b want 1", irq);
    end
    level = 8'h01;
    for (int k = 0; k < 19; k++) tick();
    n_cmp++;
    if (event_pending !== 8'h03) begin
      n_err++;
      $display("FAIL sticky_fall_ch1: pend=%h want 03", event_pending);
    end
    level = 8'h03;
    for (int k = 0; k < 19; k++) tick();
    rise_enable = 8'hFF;
    tick();
    rise_enable = 8'h01;
    n_cmp++;
    if (event_pending !== 8'h03 || irq !== 1'b1) begin
      n_err++;
      $display("FAIL sticky_hold: pend=%h irq=%b want 03/1", event_pending, irq);
    end
    event_clear = 8'h01;
    tick();
    event_clear = 8'h00;
    n_cmp++;
    if (event_pending !== 8'h02) begin
      n_err++;
      $display("FAIL sticky_clear0: pend=%h want 02", event_pending);
    end
    level = 8'h01;
    for (int k = 0; k < 18; k++) tick();
    n_cmp++;
    if (neg_edge !== 8'h02) begin
      n_err++;
      $display("FAIL sticky_neg_pulse: neg=%h want 02", neg_edge);
    end
    event_clear = 8'h02;
    tick();
    event_clear = 8'h00;
    n_cmp++;
    if (event_pending !== 8'h02) begin
      n_err++;
      $display("FAIL set_beats_clear: pend=%h want 02", event_pending);
    end
    event_clear = 8'h02;
    tick();
    event_clear = 8'h00;
    n_cmp++;
    if (event_pending !== 8'h00 || irq !== 1'b1) begin
      n_err++;
      $display("FAIL sticky_clear1: pend=%h irq=%b want 00/1", event_pending, irq);
    end
    tick();
    n_cmp++;
    if (irq !== 1'b0) begin
      n_err++;
      $display("FAIL sticky_irq_fall: irq=%b want 0", irq);
    end
    level = 8'h00;
    for (int k = 0; k < 22; k++) tick();
    n_cmp++;
    if (event_pending !== 8'h00 || stable_level !== 8'h00) begin
      n_err++;
      $display("FAIL sticky_fall_disabled: pend=%h stable=%h want 00/00", event_pending, stable_level);
    end
  endtask

  task automatic test_all_channels();
    rise_enable = 8'hFF;
    fall_enable = 8'hFF;
    level = 8'hFF;
    for (int k = 1; k <= 17; k++) begin
      tick();
      n_cmp++;
      if (pos_edge !== 8'h00) begin
        n_err++;
        $display("FAIL all_early k=%0d: pos=%h want 00", k, pos_edge);
      end
    end
    tick();
    n_cmp++;
    if (pos_edge !== 8'hFF || neg_edge !== 8'h00 || event_pending !== 8'h00) begin
      n_err++;
      $display("FAIL all_pulse: pos=%h neg=%h pend=%h want FF/00/00", pos_edge, neg_edge, event_pending);
    end
    tick();
    n_cmp++;
    if (event_pending !== 8'hFF || pos_edge !== 8'h00 || irq !== 1'b0) begin
      n_err++;
      $display("FAIL all_pending: pend=%h pos=%h irq=%b want FF/00/0", event_pending, pos_edge, irq);
    end
    tick();
    n_cmp++;
    if (irq !== 1'b1) begin
      n_err++;
      $display("FAIL all_irq: irq=%b want 1", irq);
    end
    event_clear = 8'hFF;
    tick();
    event_clear = 8'h00;
    n_cmp++;
    if (event_pending !== 8'h00 || irq !== 1'b1) begin
      n_err++;
      $display("FAIL all_clear: pend=%h irq=%b want 00/1", event_pending, irq);
    end
    tick();
    n_cmp++;
    if (irq !== 1'b0) begin
      n_err++;
      $display("FAIL all_irq_fall: irq=%b want 0", irq);
    end
  endtask

  initial begin
    reset       = 1'b1;
    level       = 8'h00;
    rise_enable = 8'h00;
    fall_enable = 8'h00;
    event_clear = 8'h00;
    level_b     = 8'h00;
    rise_b      = 8'h00;
    fall_b      = 8'h00;
    clear_b     = 8'h00;
    #1;
    test_reset();
    test_reset_mid_debounce();
    test_clean_rise_fall();
    test_glitch();
    test_bypass();
    test_sticky();
    test_all_channels();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
